// File: rtl/warp_ifetch_pkg.sv
// Shared constants and helpers for the warp instruction-fetch stage.
// Covers the instruction/PC widths, the PC step and the drop-counter width.
package warp_ifetch_pkg;

    localparam int INSTR_W   = 32;
    localparam int PC_W      = 32;
    localparam int PC_STEP   = 4;
    localparam int DROPCNT_W = 16;

    // Byte PC to I-cache word index; callers truncate to their cache address width
    function automatic logic [PC_W-1:0] pc_word_addr(input logic [PC_W-1:0] pc);
        return pc >> $clog2(PC_STEP);
    endfunction

endpackage

// File: rtl/warp_ifetch_stage_reg.sv
// One fetch pipeline stage: valid bit plus payload, with clear (highest
// priority) and hold. The payload only loads when an incoming valid arrives.
module warp_ifetch_stage_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         hold,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= load;
            if (load) begin
                q <= data;
            end
        end
    end

endmodule

// File: rtl/warp_ifetch.sv
// Two-stage instruction fetch for one warp: stage 2 tracks the I-cache read,
// stage 3 holds the returned instruction for decode.
module warp_ifetch
    import warp_ifetch_pkg::*;
#(
    parameter int DATA  = INSTR_W,
    parameter int ADDR  = 12,
    parameter int CNT_W = DROPCNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  PC_in_PC_IF,
    input  logic             GRT_RR_IF,
    input  logic             Flush_IF,
    input  logic             Stall_ID_IF,
    output logic             Req_IF_ICache,
    output logic [ADDR-1:0]  Addr_IF_ICache,
    input  logic [DATA-1:0]  Data_ICache_IF,
    output logic             valid_2_IF_PC,
    output logic             valid_3_IF_PC,
    output logic             Valid_IF_ID,
    output logic [DATA-1:0]  Instr_IF_ID,
    output logic [PC_W-1:0]  PC_IF_ID,
    output logic [CNT_W-1:0] DropCnt_IF
);

    logic            hold3;
    logic            req;
    logic            valid_2;
    logic            valid_3;
    logic [PC_W-1:0] pc_2;
    logic [DATA-1:0] instr_3;
    logic [PC_W-1:0] pc_3;
    logic [CNT_W-1:0] drop_cnt_reg;

    assign hold3 = valid_3 & Stall_ID_IF;
    // Gating with rst_n keeps the cache strobe quiet while reset is asserted
    assign req   = rst_n & GRT_RR_IF & ~Flush_IF & ~hold3;

    assign Req_IF_ICache  = req;
    assign Addr_IF_ICache = ADDR'(pc_word_addr(PC_in_PC_IF));

    warp_ifetch_stage_reg #(.W(PC_W)) u_stage2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .hold  (1'b0),
        .load  (req),
        .data  (PC_in_PC_IF),
        .valid (valid_2),
        .q     (pc_2)
    );

    // While stage 3 holds, stage 2 still advances, so its fetch is lost
    warp_ifetch_stage_reg #(.W(DATA + PC_W)) u_stage3 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (Flush_IF),
        .hold  (hold3),
        .load  (valid_2),
        .data  ({Data_ICache_IF, pc_2}),
        .valid (valid_3),
        .q     ({instr_3, pc_3})
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (!Flush_IF && hold3 && valid_2 && (drop_cnt_reg != '1)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign valid_2_IF_PC = valid_2;
    assign valid_3_IF_PC = valid_3;
    assign Valid_IF_ID   = valid_3 & ~Flush_IF;
    assign Instr_IF_ID   = instr_3;
    assign PC_IF_ID      = pc_3;
    assign DropCnt_IF    = drop_cnt_reg;

endmodule

// File: tb/tb_warp_ifetch.sv
// Directed bench for warp_ifetch: reset, streaming, stall/drop, flush,
// flush+stall and counter saturation on a narrow-counter instance.
module tb_warp_ifetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        grt;
    logic        flush;
    logic        stall;
    logic        req;
    logic [11:0] addr;
    logic [31:0] data;
    logic        v2;
    logic        v3;
    logic        vid;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic [15:0] dropcnt;

    logic [31:0] s_pc_in;
    logic        s_grt;
    logic        s_flush;
    logic        s_stall;
    logic        s_req;
    logic [11:0] s_addr;
    logic [31:0] s_data;
    logic        s_v2;
    logic        s_v3;
    logic        s_vid;
    logic [31:0] s_instr;
    logic [31:0] s_pc_id;
    logic [3:0]  s_dropcnt;

    int n_checks = 0;
    int n_fail   = 0;

    warp_ifetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_in_PC_IF    (pc_in),
        .GRT_RR_IF      (grt),
        .Flush_IF       (flush),
        .Stall_ID_IF    (stall),
        .Req_IF_ICache  (req),
        .Addr_IF_ICache (addr),
        .Data_ICache_IF (data),
        .valid_2_IF_PC  (v2),
        .valid_3_IF_PC  (v3),
        .Valid_IF_ID    (vid),
        .Instr_IF_ID    (instr),
        .PC_IF_ID       (pc_id),
        .DropCnt_IF     (dropcnt)
    );

    warp_ifetch #(.CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_in_PC_IF    (s_pc_in),
        .GRT_RR_IF      (s_grt),
        .Flush_IF       (s_flush),
        .Stall_ID_IF    (s_stall),
        .Req_IF_ICache  (s_req),
        .Addr_IF_ICache (s_addr),
        .Data_ICache_IF (s_data),
        .valid_2_IF_PC  (s_v2),
        .valid_3_IF_PC  (s_v3),
        .Valid_IF_ID    (s_vid),
        .Instr_IF_ID    (s_instr),
        .PC_IF_ID       (s_pc_id),
        .DropCnt_IF     (s_dropcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_in = '0; grt = 1'b1; flush = 1'b0; stall = 1'b0; data = '0;
        s_pc_in = '0; s_grt = 1'b0; s_flush = 1'b0; s_stall = 1'b0; s_data = '0;
        #2;
        chk("reset_req", req, 0);
        chk("reset_v2", v2, 0);
        chk("reset_v3", v3, 0);
        chk("reset_valid", vid, 0);
        chk("reset_dropcnt", dropcnt, 0);
        tick();
        rst_n = 1'b1; grt = 1'b0;

        // Back-to-back stream
        grt = 1'b1; pc_in = 32'h100; settle();
        chk("s_req", req, 1);
        chk("s_addr0", addr, 12'h040);
        tick();
        pc_in = 32'h104; data = 32'hAAAA_0001; settle();
        chk("s_v2", v2, 1);
        chk("s_v3", v3, 0);
        chk("s_addr1", addr, 12'h041);
        tick();
        pc_in = 32'h108; data = 32'hBBBB_0002; settle();
        chk("s_valid0", vid, 1);
        chk("s_pc0", pc_id, 32'h100);
        chk("s_instr0", instr, 32'hAAAA_0001);
        tick();
        grt = 1'b0; data = 32'hCCCC_0003; settle();
        chk("s_valid1", vid, 1);
        chk("s_pc1", pc_id, 32'h104);
        chk("s_instr1", instr, 32'hBBBB_0002);
        tick();
        data = 32'hDEAD_DEAD; settle();
        chk("s_valid2", vid, 1);
        chk("s_pc2", pc_id, 32'h108);
        chk("s_instr2", instr, 32'hCCCC_0003);
        chk("s_v2_idle", v2, 0);
        tick();
        chk("s_drained", vid, 0);

        // Stall: 0x100 held, 0x104 dropped
        grt = 1'b1; pc_in = 32'h100; tick();
        pc_in = 32'h104; data = 32'h1111_0000; tick();
        stall = 1'b1; pc_in = 32'h108; data = 32'h2222_0000; settle();
        chk("st_v2", v2, 1);
        chk("st_v3", v3, 1);
        chk("st_req", req, 0);
        chk("st_valid", vid, 1);
        tick();
        stall = 1'b0; pc_in = 32'h104; settle();
        chk("st_dropcnt", dropcnt, 1);
        chk("st_v2_after", v2, 0);
        chk("st_pc_held", pc_id, 32'h100);
        chk("st_instr_held", instr, 32'h1111_0000);
        chk("st_refetch_req", req, 1);
        tick();
        grt = 1'b0; data = 32'h3333_0000; settle();
        chk("st_gap", vid, 0);
        tick();
        chk("st_refetch_pc", pc_id, 32'h104);
        chk("st_refetch_instr", instr, 32'h3333_0000);
        tick();

        // Flush with both stages occupied
        grt = 1'b1; pc_in = 32'h200; tick();
        pc_in = 32'h204; data = 32'h4444_0000; tick();
        flush = 1'b1; pc_in = 32'h208; settle();
        chk("fl_valid", vid, 0);
        chk("fl_req", req, 0);
        tick();
        flush = 1'b0; grt = 1'b0; settle();
        chk("fl_v2", v2, 0);
        chk("fl_v3", v3, 0);

        // Flush and stall together: flush wins, no drop counted
        grt = 1'b1; pc_in = 32'h300; tick();
        pc_in = 32'h304; data = 32'h5555_0000; tick();
        flush = 1'b1; stall = 1'b1; settle();
        chk("fs_req", req, 0);
        tick();
        flush = 1'b0; stall = 1'b0; grt = 1'b0; settle();
        chk("fs_v3", v3, 0);
        chk("fs_v2", v2, 0);
        chk("fs_dropcnt", dropcnt, 1);

        // Asynchronous reset mid-fetch
        grt = 1'b1; pc_in = 32'h400; tick();
        grt = 1'b0; #2;
        rst_n = 1'b0; #1;
        chk("ar_v2", v2, 0);
        chk("ar_dropcnt", dropcnt, 0);
        chk("ar_req", req, 0);
        data = 32'h6666_0000; tick();
        rst_n = 1'b1; settle();
        chk("ar_v3", v3, 0);
        chk("ar_valid", vid, 0);

        // Saturation on the 4-bit counter instance
        s_pc_in = 32'h500;
        for (int i = 0; i < 20; i++) begin
            s_grt = 1'b1; s_stall = 1'b0; tick();
            tick();
            s_stall = 1'b1; tick();
            chk("sat_cnt", {60'd0, s_dropcnt}, (i < 15) ? 64'(i + 1) : 64'd15);
        end
        s_stall = 1'b0; s_grt = 1'b0;
        chk("sat_main_dropcnt", dropcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
